// File: rtl/spike_sched_pkg.sv
// Shared types and default widths for the spike step scheduler.
package spike_sched_pkg;

  localparam int DEF_STEP_NUMBER   = 32;
  localparam int DEF_CLK_PER_STEP  = 64;
  localparam int DEF_INJECT_WINDOW = 32;
  localparam int DEF_PKT_WIDTH     = 32;
  localparam int DEF_STEP_W        = 8;
  localparam int DEF_FIFO_DEPTH    = 16;
  localparam int DEF_FIFO_AW       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_INJECT,
    ST_WAIT,
    ST_DONE
  } state_e;

  // The time-step tag lives in the top STEP_W bits of a packet.
  function automatic logic [DEF_STEP_W-1:0] pkt_tag(input logic [DEF_PKT_WIDTH-1:0] pkt);
    return DEF_STEP_W'(pkt >> (DEF_PKT_WIDTH - DEF_STEP_W));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head view so the consumer can
// inspect and pop the oldest entry in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop  && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/spike_step_scheduler.sv
// Time-step sequencer for the neuromorphic mesh: emits per-step start pulses
// and injects queued host spike packets during the step named by their tag.
module spike_step_scheduler
  import spike_sched_pkg::*;
#(
  parameter int STEP_NUMBER   = DEF_STEP_NUMBER,
  parameter int CLK_PER_STEP  = DEF_CLK_PER_STEP,
  parameter int INJECT_WINDOW = DEF_INJECT_WINDOW,
  parameter int PKT_WIDTH     = DEF_PKT_WIDTH,
  parameter int STEP_W        = DEF_STEP_W,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int FIFO_AW       = DEF_FIFO_AW
) (
  input  logic                 neu_clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [PKT_WIDTH-1:0] host_pkt,
  input  logic                 host_valid,
  output logic                 host_ready,
  output logic                 start,
  output logic [PKT_WIDTH-1:0] spike_packet,
  output logic                 write_req,
  input  logic                 receive_full,
  output logic [STEP_W-1:0]    step_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun,
  output logic                 late_drop
);

  localparam int                CW        = $clog2(CLK_PER_STEP);
  localparam logic [CW-1:0]     WIN_LAST  = CW'(INJECT_WINDOW);
  localparam logic [CW-1:0]     CNT_LAST  = CW'(CLK_PER_STEP - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_NUMBER - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cycle_cnt_q, cycle_cnt_d;
  logic [STEP_W-1:0]   step_idx_q, step_idx_d;
  logic                run_prev_q, run_prev_d;
  logic                ready_en_q, ready_en_d;

  logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [PKT_WIDTH-1:0] fifo_head;
  logic [STEP_W-1:0]   head_tag;
  logic                tag_hit;

  sync_fifo #(
    .WIDTH (PKT_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk       (neu_clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (host_pkt),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  generate
    if (PKT_WIDTH == DEF_PKT_WIDTH && STEP_W == DEF_STEP_W) begin : g_tag_pkg
      assign head_tag = pkt_tag(fifo_head);
    end else begin : g_tag_slice
      assign head_tag = fifo_head[PKT_WIDTH-1 -: STEP_W];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    step_idx_d  = step_idx_q;
    run_prev_d  = run;
    ready_en_d  = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (run && !run_prev_q) state_d = ST_START;
      end
      ST_START: begin
        cycle_cnt_d = CW'(1);
        state_d     = ST_INJECT;
      end
      ST_INJECT: begin
        cycle_cnt_d = cycle_cnt_q + 1'b1;
        if (cycle_cnt_q == WIN_LAST) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cycle_cnt_q == CNT_LAST) begin
          cycle_cnt_d = '0;
          if (step_idx_q == STEP_LAST) begin
            state_d = ST_DONE;
          end else begin
            step_idx_d = step_idx_q + 1'b1;
            state_d    = ST_START;
          end
        end else begin
          cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (!run) begin
          state_d    = ST_IDLE;
          step_idx_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Injection decisions depend only on registered state, the FIFO head and receive_full.
  always_comb begin
    tag_hit      = !fifo_empty && (head_tag == step_idx_q);
    write_req    = (state_q == ST_INJECT) && tag_hit && !receive_full;
    late_drop    = ((state_q == ST_INJECT) || (state_q == ST_WAIT)) &&
                   !fifo_empty && (head_tag < step_idx_q);
    overrun      = (state_q == ST_INJECT) && (cycle_cnt_q == WIN_LAST) &&
                   tag_hit && receive_full;
    spike_packet = write_req ? fifo_head : '0;
  end

  assign start      = (state_q == ST_START);
  assign busy       = (state_q == ST_START) || (state_q == ST_INJECT) || (state_q == ST_WAIT);
  assign done       = (state_q == ST_DONE);
  assign step_idx   = step_idx_q;
  assign host_ready = ready_en_q && !fifo_full;
  assign fifo_push  = host_valid && host_ready;
  assign fifo_pop   = write_req || late_drop;

  // run_prev resets high so a run level held across reset is not taken as a new edge.
  always_ff @(posedge neu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cycle_cnt_q <= '0;
      step_idx_q  <= '0;
      run_prev_q  <= 1'b1;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      step_idx_q  <= step_idx_d;
      run_prev_q  <= run_prev_d;
      ready_en_q  <= ready_en_d;
    end
  end

endmodule

// File: tb/tb_spike_step_scheduler.sv
// Randomized and directed bench for spike_step_scheduler against a
// step/cycle arithmetic model with a packet queue.
module tb_spike_step_scheduler;

  localparam int SN    = 4;
  localparam int CPS   = 8;
  localparam int IW    = 4;
  localparam int PW    = 32;
  localparam int SW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          neu_clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          run = 1'b0;
  logic          host_valid = 1'b0;
  logic          receive_full = 1'b0;
  logic [PW-1:0] host_pkt = '0;
  logic          host_ready, start, write_req, busy, done, overrun, late_drop;
  logic [PW-1:0] spike_packet;
  logic [SW-1:0] step_idx;

  int vectors = 0;
  int errors  = 0;
  int cyc_n   = 0;

  // reference model: mode 0 idle, 1 running, 2 done; m_g = cycles since run start
  logic [PW-1:0] q[$];
  int            m_mode, m_g;
  bit            m_run_prev, m_rdy;

  int n_start, n_wr, n_ovr, n_drop;
  int t_start, t_last, t_done, t_wr, t_ovr, t_drop;

  always #5 neu_clk = ~neu_clk;

  spike_step_scheduler #(
    .STEP_NUMBER   (SN),
    .CLK_PER_STEP  (CPS),
    .INJECT_WINDOW (IW),
    .PKT_WIDTH     (PW),
    .STEP_W        (SW),
    .FIFO_DEPTH    (DEPTH),
    .FIFO_AW       (AW)
  ) dut (
    .neu_clk      (neu_clk),
    .rst_n        (rst_n),
    .run          (run),
    .host_pkt     (host_pkt),
    .host_valid   (host_valid),
    .host_ready   (host_ready),
    .start        (start),
    .spike_packet (spike_packet),
    .write_req    (write_req),
    .receive_full (receive_full),
    .step_idx     (step_idx),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun),
    .late_drop    (late_drop)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc_n, got, exp);
    end
  endtask

  task automatic clr_ev();
    n_start = 0; n_wr = 0; n_ovr = 0; n_drop = 0;
    t_start = -1; t_last = -1; t_done = -1; t_wr = -1; t_ovr = -1; t_drop = -1;
  endtask

  task automatic do_reset(input logic r);
    run = r; host_valid = 1'b0; receive_full = 1'b0; host_pkt = '0;
    rst_n = 1'b0;
    #1;
    check("rst_host_ready", host_ready, 0);
    check("rst_start", start, 0);
    check("rst_write_req", write_req, 0);
    check("rst_spike_packet", spike_packet, 0);
    check("rst_step_idx", step_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_late_drop", late_drop, 0);
    q.delete();
    m_mode = 0; m_g = 0; m_run_prev = 1'b1; m_rdy = 1'b0;
    @(negedge neu_clk);
    @(negedge neu_clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic cyc(input logic r, input logic hv, input logic [PW-1:0] pkt, input logic rf);
    int            c, s;
    bit            ne;
    logic [PW-1:0] hd;
    logic [SW-1:0] tg, e_step;
    logic          e_wr, e_drop, e_ovr, e_rdy;
    run = r; host_valid = hv; host_pkt = pkt; receive_full = rf;
    #1;
    c      = m_g % CPS;
    s      = m_g / CPS;
    ne     = (q.size() != 0);
    hd     = ne ? q[0] : '0;
    tg     = hd[PW-1 -: SW];
    e_rdy  = m_rdy && (q.size() < DEPTH);
    e_wr   = (m_mode == 1) && (c >= 1) && (c <= IW) && ne && (int'(tg) == s) && !rf;
    e_drop = (m_mode == 1) && (c >= 1) && ne && (int'(tg) < s);
    e_ovr  = (m_mode == 1) && (c == IW) && ne && (int'(tg) == s) && rf;
    e_step = (m_mode == 1) ? SW'(s) : ((m_mode == 2) ? SW'(SN - 1) : '0);
    check("start", start, (m_mode == 1) && (c == 0));
    check("busy", busy, m_mode == 1);
    check("done", done, m_mode == 2);
    check("step_idx", step_idx, e_step);
    check("host_ready", host_ready, e_rdy);
    check("write_req", write_req, e_wr);
    check("spike_packet", spike_packet, e_wr ? hd : '0);
    check("late_drop", late_drop, e_drop);
    check("overrun", overrun, e_ovr);
    if (start) begin
      if (t_start < 0) t_start = cyc_n;
      t_last = cyc_n;
      n_start++;
    end
    if (done && t_done < 0) t_done = cyc_n;
    if (write_req) begin
      if (t_wr < 0) t_wr = cyc_n;
      n_wr++;
      $display("cyc %0d step %0d write %h", cyc_n, step_idx, spike_packet);
    end
    if (late_drop) begin
      if (t_drop < 0) t_drop = cyc_n;
      n_drop++;
      $display("cyc %0d step %0d stale drop", cyc_n, step_idx);
    end
    if (overrun) begin
      if (t_ovr < 0) t_ovr = cyc_n;
      n_ovr++;
      $display("cyc %0d step %0d overrun", cyc_n, step_idx);
    end
    if (e_wr || e_drop) void'(q.pop_front());
    if (hv && e_rdy) q.push_back(pkt);
    case (m_mode)
      0: if (r && !m_run_prev) begin m_mode = 1; m_g = 0; end
      1: begin m_g++; if (m_g == SN * CPS) m_mode = 2; end
      default: if (!r) m_mode = 0;
    endcase
    m_run_prev = r;
    m_rdy = 1'b1;
    cyc_n++;
    @(negedge neu_clk);
  endtask

  // Full run with run held high; sc selects the receive_full / host pattern.
  task automatic run_scenario(input int sc);
    logic rf, hv;
    int   c, s;
    for (int i = 0; i < 38; i++) begin
      c  = m_g % CPS;
      s  = m_g / CPS;
      rf = 1'b0;
      hv = 1'b0;
      if (sc == 1) hv = (m_mode == 1) && (m_g == 1);
      if (sc == 2) rf = (m_mode == 1) && (s == 0) && (c >= 1) && (c <= 3);
      if (sc == 3) rf = (m_mode == 1) && (s == 0) && (c >= 1);
      cyc(1'b1, hv, 32'h02DEAD00, rf);
    end
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic          rr, hv_r, rf_r;
    logic [PW-1:0] pk;
    @(negedge neu_clk);
    do_reset(1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);

    // empty FIFO run
    clr_ev();
    run_scenario(0);
    check("s0_starts", n_start, 4);
    check("s0_start_span", t_last - t_start, 24);
    check("s0_done_at", t_done - t_start, 32);
    check("s0_writes", n_wr, 0);

    // preload tags 0,0,1,3 then a refused 5th push
    clr_ev();
    cyc(1'b0, 1'b1, 32'h00111111, 1'b0);
    cyc(1'b0, 1'b1, 32'h00222222, 1'b0);
    cyc(1'b0, 1'b1, 32'h01333333, 1'b0);
    cyc(1'b0, 1'b1, 32'h03444444, 1'b0);
    check("s1_full_ready", host_ready, 0);
    cyc(1'b0, 1'b1, 32'h00FFFFFF, 1'b0);
    run_scenario(1);
    check("s1_writes", n_wr, 4);
    check("s1_first_write", t_wr - t_start, 1);
    check("s1_drops", n_drop, 0);

    // receive_full for window cycles 1..3
    clr_ev();
    cyc(1'b0, 1'b1, 32'h00ABCDEF, 1'b0);
    run_scenario(2);
    check("s2_writes", n_wr, 1);
    check("s2_write_cycle", t_wr - t_start, 4);
    check("s2_overruns", n_ovr, 0);

    // receive_full through the whole window
    clr_ev();
    cyc(1'b0, 1'b1, 32'h00C0FFEE, 1'b0);
    run_scenario(3);
    check("s3_writes", n_wr, 0);
    check("s3_overruns", n_ovr, 1);
    check("s3_overrun_cycle", t_ovr - t_start, 4);
    check("s3_drops", n_drop, 1);
    check("s3_drop_cycle", t_drop - t_start, 9);

    // randomized traffic
    rr = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 15) == 0) rr = ~rr;
      hv_r = 1'($urandom_range(0, 1));
      rf_r = ($urandom_range(0, 3) == 0);
      pk   = {8'($urandom_range(0, 3)), 24'($urandom)};
      cyc(rr, hv_r, pk, rf_r);
    end

    // reset mid step 2, then require a fresh run edge
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    if (m_mode != 0) begin
      for (int i = 0; i < 60 && m_mode != 0; i++) cyc(1'b0, 1'b0, '0, 1'b0);
    end
    for (int i = 0; i < 100; i++) begin
      if (m_mode == 1 && m_g == 2 * CPS + 3) break;
      cyc(1'b1, 1'b1, 32'h02000000, 1'b0);
    end
    check("pre_reset_busy", busy, 1);
    check("pre_reset_step", step_idx, 2);
    do_reset(1'b1);
    clr_ev();
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, '0, 1'b0);
    check("post_reset_no_start", n_start, 0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, '0, 1'b0);
    check("post_reset_restart", n_start, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
